// File: rtl/glyph_readback.sv
// Reads one 8x8 character cell from the byte-per-pixel framebuffer and
// repacks it into eight 1-bpp row bytes (bit 7 = leftmost pixel).
module glyph_readback #(
  parameter int unsigned PIXEL_WIDTH        = 640,
  parameter int unsigned SCREEN_CHAR_WIDTH  = 80,
  parameter int unsigned SCREEN_CHAR_HEIGHT = 50,
  parameter logic [7:0]  INK                = 8'hff,
  parameter int unsigned RD_LATENCY         = 1
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  cell_x,
  input  logic [5:0]  cell_y,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  row_byte,
  output logic [2:0]  row_index,
  output logic        row_valid,
  output logic        done,
  output logic        busy,
  output logic        error
);

  localparam int unsigned CELL_PITCH = 8 * PIXEL_WIDTH;
  localparam int unsigned ROW_STEP   = PIXEL_WIDTH - 7;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state, state_d;
  logic        rd_en_d, busy_d, error_d;
  logic [31:0] rd_addr_d;
  logic [5:0]  rd_cnt, rd_cnt_d;
  logic        in_range_c;
  logic [31:0] base_c;

  logic [RD_LATENCY-1:0] tag;
  logic                  pix_vld_c, pix_bit_c;
  logic [2:0]            pix_col, pix_row;
  logic [7:0]            asm_q;

  assign in_range_c = (32'(cell_x) < SCREEN_CHAR_WIDTH) &&
                      (32'(cell_y) < SCREEN_CHAR_HEIGHT);
  assign base_c     = 32'(cell_y) * 32'(CELL_PITCH) + 32'(cell_x) * 32'd8;

  // State and request-side registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_en   <= 1'b0;
      rd_addr <= 32'd0;
      rd_cnt  <= 6'd0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      rd_cnt  <= rd_cnt_d;
      busy    <= busy_d;
      error   <= error_d;
    end
  end

  // Next-state: rd_cnt indexes the read currently on the bus (row = [5:3], col = [2:0])
  always_comb begin
    state_d   = state;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    rd_cnt_d  = rd_cnt;
    error_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_range_c) begin
            state_d   = ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = base_c;
            rd_cnt_d  = 6'd0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (rd_cnt == 6'd63) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_cnt_d  = rd_cnt + 6'd1;
          rd_addr_d = rd_addr + ((rd_cnt[2:0] == 3'd7) ? 32'(ROW_STEP) : 32'd1);
        end
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // rd_en shadow marks which cycles carry our returning data
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  assign pix_vld_c = tag[RD_LATENCY-1];
  assign pix_bit_c = (rd_data == INK);

  // Shift pixels in from the LSB so column 0 lands in bit 7
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= 8'd0;
      pix_col   <= 3'd0;
      pix_row   <= 3'd0;
      row_byte  <= 8'd0;
      row_index <= 3'd0;
      row_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      done      <= 1'b0;
      if (pix_vld_c) begin
        pix_col <= pix_col + 3'd1;
        if (pix_col == 3'd7) begin
          row_byte  <= {asm_q[6:0], pix_bit_c};
          row_index <= pix_row;
          row_valid <= 1'b1;
          done      <= (pix_row == 3'd7);
          asm_q     <= 8'd0;
          pix_row   <= pix_row + 3'd1;
        end else begin
          asm_q <= {asm_q[6:0], pix_bit_c};
        end
      end
    end
  end

endmodule

// File: tb/tb_glyph_readback.sv
// Drives glyph_readback at RD_LATENCY 1 and 4 side by side against a shared
// framebuffer model and checks addresses, timing and packed rows.
module tb_glyph_readback;

  localparam int PW   = 640;
  localparam int FB_N = 640 * 400;

  logic              pclk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [6:0]        cell_x;
  logic [5:0]        cell_y;
  logic [1:0]        rd_en;
  logic [1:0][31:0]  rd_addr;
  logic [1:0][7:0]   rd_data;
  logic [1:0][7:0]   row_byte;
  logic [1:0][2:0]   row_index;
  logic [1:0]        row_valid;
  logic [1:0]        done;
  logic [1:0]        busy;
  logic [1:0]        error;

  logic [7:0] mem [FB_N];
  logic [7:0] dpipe [2][4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  glyph_readback #(.RD_LATENCY(1)) dut1 (
    .pclk(pclk), .rst_n(rst_n), .start(start), .cell_x(cell_x), .cell_y(cell_y),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .row_byte(row_byte[0]), .row_index(row_index[0]), .row_valid(row_valid[0]),
    .done(done[0]), .busy(busy[0]), .error(error[0]));

  glyph_readback #(.RD_LATENCY(4)) dut4 (
    .pclk(pclk), .rst_n(rst_n), .start(start), .cell_x(cell_x), .cell_y(cell_y),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .row_byte(row_byte[1]), .row_index(row_index[1]), .row_valid(row_valid[1]),
    .done(done[1]), .busy(busy[1]), .error(error[1]));

  function automatic logic [7:0] fetch(input logic en, input logic [31:0] a);
    if (!en) return 8'h33;
    return (a < 32'(FB_N)) ? mem[a] : 8'h00;
  endfunction

  // Framebuffer read port: fixed latency per instance, filler on idle cycles
  always @(posedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      dpipe[i][0] <= fetch(rd_en[i], rd_addr[i]);
      for (int s = 1; s < 4; s++) dpipe[i][s] <= dpipe[i][s-1];
    end
  end
  assign rd_data[0] = dpipe[0][0];
  assign rd_data[1] = dpipe[1][3];

  function automatic int cell_base(input int x, input int y);
    return y * 8 * PW + x * 8;
  endfunction

  // Reference: a bitmap bit is set exactly where the pixel equals INK
  function automatic logic [7:0] model_row(input int x, input int y, input int r);
    logic [7:0] b;
    for (int c = 0; c < 8; c++) b[7-c] = (mem[cell_base(x, y) + r * PW + c] == 8'hff);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cell(input int x, input int y, input logic [7:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[cell_base(x, y) + r * PW + c] = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++)
      chk(tag, 64'({rd_en[i], rd_addr[i], row_byte[i], row_index[i],
                    row_valid[i], done[i], busy[i], error[i]}), 64'd0);
  endtask

  int          nrd [2], first_k [2], last_k [2], addr_bad [2];
  int          nrow [2], idx_bad [2], done_k [2], busy_bad [2], err_cnt [2], err_k [2];
  logic [31:0] first_a [2], last_a [2];
  int          row_k [2][8];
  logic [7:0]  row_b [2][8];

  task automatic run_cell(input int x, input int y, input bit ok,
                          input int poke_k, input int abort_k);
    int base, lat, e;
    base = cell_base(x, y);
    for (int i = 0; i < 2; i++) begin
      nrd[i] = 0; first_k[i] = -1; last_k[i] = -1; addr_bad[i] = 0;
      nrow[i] = 0; idx_bad[i] = 0; done_k[i] = -1; busy_bad[i] = 0;
      err_cnt[i] = 0; err_k[i] = -1; first_a[i] = '0; last_a[i] = '0;
    end
    @(posedge pclk); #1;
    cell_x = 7'(x); cell_y = 6'(y); start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge pclk);
      for (int i = 0; i < 2; i++) begin
        lat = (i == 0) ? 1 : 4;
        if (rd_en[i]) begin
          e = base + (nrd[i] / 8) * PW + nrd[i] % 8;
          if (nrd[i] == 0) begin first_k[i] = k; first_a[i] = rd_addr[i]; end
          if (rd_addr[i] !== 32'(e)) addr_bad[i]++;
          last_k[i] = k; last_a[i] = rd_addr[i];
          nrd[i]++;
        end
        if (row_valid[i] === 1'b1) begin
          if (nrow[i] < 8) begin
            row_k[i][nrow[i]] = k; row_b[i][nrow[i]] = row_byte[i];
            if (row_index[i] !== 3'(nrow[i])) idx_bad[i]++;
          end
          nrow[i]++;
        end
        if (done[i] === 1'b1) done_k[i] = k;
        if (error[i] === 1'b1) begin err_cnt[i]++; err_k[i] = k; end
        if (busy[i] !== (ok && k <= 65 + lat)) busy_bad[i]++;
      end
      if (k == poke_k) start = 1'b1;
      if (k == poke_k + 1) start = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset_outputs");
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 4;
      if (ok) begin
        chk("read_count", 64'(nrd[i]), 64'd64);
        chk("first_read_cycle", 64'(first_k[i]), 64'd1);
        chk("last_read_cycle", 64'(last_k[i]), 64'd64);
        chk("first_addr", 64'(first_a[i]), 64'(base));
        chk("last_addr", 64'(last_a[i]), 64'(base + 7 * PW + 7));
        chk("addr_sequence_errors", 64'(addr_bad[i]), 64'd0);
        chk("row_count", 64'(nrow[i]), 64'd8);
        chk("row_index_errors", 64'(idx_bad[i]), 64'd0);
        for (int r = 0; r < 8; r++) begin
          chk("row_valid_cycle", 64'(row_k[i][r]), 64'(9 + 8 * r + lat));
          chk("row_byte", 64'(row_b[i][r]), 64'(model_row(x, y, r)));
        end
        chk("done_cycle", 64'(done_k[i]), 64'(65 + lat));
        chk("busy_window_errors", 64'(busy_bad[i]), 64'd0);
        chk("spurious_error", 64'(err_cnt[i]), 64'd0);
      end else begin
        chk("reject_reads", 64'(nrd[i]), 64'd0);
        chk("reject_error_count", 64'(err_cnt[i]), 64'd1);
        chk("reject_error_cycle", 64'(err_k[i]), 64'd1);
        chk("reject_busy_errors", 64'(busy_bad[i]), 64'd0);
      end
    end
  endtask

  logic [7:0] font_a [8];

  initial begin
    font_a = '{8'h18, 8'h3c, 8'h66, 8'h66, 8'h7e, 8'h66, 8'h66, 8'h00};
    for (int a = 0; a < FB_N; a++) mem[a] = 8'h00;
    rst_n = 1'b0; start = 1'b0; cell_x = '0; cell_y = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;

    // Glyph 'A' written the way the blitter would, at cell (0,0)
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r * PW + c] = font_a[r][7-c] ? 8'hff : 8'h00;
    run_cell(0, 0, 1'b1, -1, -1);
    for (int r = 0; r < 8; r++) chk("glyph_a_row", 64'(row_b[0][r]), 64'(font_a[r]));

    // Bottom-right cell, all ink then all background
    clear_cell(79, 49, 8'hff);
    run_cell(79, 49, 1'b1, -1, -1);
    chk("corner_first_addr", 64'(first_a[0]), 64'd251512);
    chk("corner_last_addr", 64'(last_a[1]), 64'd255999);
    chk("all_ink_row", 64'(row_b[1][5]), 64'hff);
    clear_cell(79, 49, 8'h00);
    run_cell(79, 49, 1'b1, -1, -1);
    chk("all_bg_row", 64'(row_b[0][2]), 64'h00);

    // Bit order with a near-ink pixel; start poked mid-run must be ignored
    clear_cell(5, 2, 8'h00);
    mem[cell_base(5, 2) + 3 * PW] = 8'hff;
    mem[cell_base(5, 2) + 5 * PW + 2] = 8'hfe;
    run_cell(5, 2, 1'b1, 20, -1);
    chk("bitorder_first_addr", 64'(first_a[0]), 64'd10280);
    chk("bitorder_row3", 64'(row_b[0][3]), 64'h80);
    chk("bitorder_row5_fe", 64'(row_b[1][5]), 64'h00);

    // Out-of-range requests
    run_cell(80, 0, 1'b0, -1, -1);
    run_cell(0, 50, 1'b0, -1, -1);

    // Random cells with random pixel content
    for (int n = 0; n < 4; n++) begin
      int x, y;
      x = int'($urandom_range(79, 0));
      y = int'($urandom_range(49, 0));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          int v;
          v = int'($urandom_range(2, 0));
          mem[cell_base(x, y) + r * PW + c] = (v == 0) ? 8'hff : ((v == 1) ? 8'hfe : 8'(($urandom)));
        end
      run_cell(x, y, 1'b1, -1, -1);
    end

    // Abort mid-cell, then a clean cell (1,1)
    clear_cell(3, 3, 8'hff);
    run_cell(3, 3, 1'b1, -1, 30);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[cell_base(1, 1) + r * PW + c] = ((r + c) % 3 == 0) ? 8'hff : 8'h00;
    run_cell(1, 1, 1'b1, -1, -1);
    chk("post_reset_first_addr", 64'(first_a[0]), 64'd5128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/glyph_readback.md
# glyph_readback

Reads one 8x8 character cell back out of the 640x400 byte-per-pixel framebuffer and repacks it into eight 1-bpp row bytes in font-bitmap bit order. It is the inverse of the font blitter: the blitter expands bitmap bits into pixel writes, and this block collapses pixel reads back into bitmap bits. It sits on the framebuffer read port, in the pixel-clock domain. Uses include glyph verification, screen scrape and cell copy.

## Interface
Parameters:
- PIXEL_WIDTH, 640: framebuffer line pitch in pixels.
- SCREEN_CHAR_WIDTH, 80: cell columns.
- SCREEN_CHAR_HEIGHT, 50: cell rows.
- INK, 8'hff: pixel value that decodes to bit 1. Any other value decodes to 0.
- RD_LATENCY, 1: fixed framebuffer read latency in cycles. Legal range 1–4.

Ports:
- pclk, in, 1: the only clock. All logic runs on the rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: single-cycle request. Sampled only in IDLE.
- cell_x, in, 7: cell column, 0–79.
- cell_y, in, 6: cell row, 0–49.
- rd_en, out, 1: framebuffer read strobe.
- rd_addr, out, 32: pixel byte address.
- rd_data, in, 8: pixel value. Valid RD_LATENCY cycles after the matching rd_en.
- row_byte, out, 8: packed row. Bit 7 is the leftmost pixel.
- row_index, out, 3: row number of row_byte, 0–7.
- row_valid, out, 1: one-cycle qualifier for row_byte and row_index.
- done, out, 1: one-cycle pulse, coincident with row 7's row_valid.
- busy, out, 1: high from the cycle after an accepted start until the cycle after done.
- error, out, 1: one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with cell_x < SCREEN_CHAR_WIDTH and cell_y < SCREEN_CHAR_HEIGHT: latch the base address, go to ISSUE, set busy.
  - start with an out-of-range cell: pulse error next cycle, issue no reads, stay in IDLE.
- Base address = cell_y*8*PIXEL_WIDTH + cell_x*8, computed in 32 bits with no truncation.
- ISSUE:
  - Exactly 64 reads, one per cycle, row-major.
  - Address = base + row*PIXEL_WIDTH + col, with col 0–7 inner and row 0–7 outer.
  - The column counter wraps 7→0 and the row counter increments; the address is an incremental add, not a multiply.
  - After the 64th read: rd_en low, go to DRAIN.
- Return tracking: a RD_LATENCY-deep shift of rd_en tags returning data. Only tagged rd_data is used.
- Decode and pack:
  - Each tagged pixel decodes to bit = (rd_data == INK).
  - The bit shifts into an 8-bit assembler from the LSB side, so col 0 ends up in bit 7.
  - On the 8th tagged pixel of a row: the next cycle drives row_byte, row_index and row_valid. The assembler clears.
- DRAIN: waits for the last tagged pixel. When row 7 is emitted, done pulses and the FSM returns to IDLE. busy drops the following cycle.
- start while busy is ignored: no queueing, no error.
- Asynchronous reset at any point, including mid-ISSUE or mid-DRAIN:
  - All outputs go to 0: rd_en, rd_addr, row_byte, row_index, row_valid, done, busy, error.
  - FSM to IDLE; all counters and the tag pipeline clear.
  - In-flight read data after reset is discarded.
- row_byte holds its last value between row_valid pulses. Consumers must not sample it without row_valid.

## Timing
- Accepted start sampled at edge of cycle T. The first rd_en is in cycle T+1 and the 64th in T+64.
- Row r has row_valid in cycle T+9+8r+RD_LATENCY.
  - RD_LATENCY=1: row 0 at T+10, row 7 and done at T+66, busy low at T+67.
- busy is high in cycles T+1 through T+8+RD_LATENCY+57 inclusive.
- A new start is accepted in the first cycle busy is low, giving back-to-back cells every 66+RD_LATENCY cycles.
- A rejected start at T pulses error in cycle T+1. busy stays low throughout.
- rd_addr is registered. It changes only with rd_en high and holds its last value otherwise.

## Test plan
- Cell (0,0), framebuffer preloaded with font glyph 'A' by the blitter:
  - rd_addr sequence is 0–7, 640–647, …, 4480–4487.
  - The eight row_bytes equal the font bytes for 'A'.
  - row_index runs 0–7 and done coincides with row 7.
- Cell (79,49):
  - The first address is 251512 and the last is 255999.
  - All-INK memory gives eight row_bytes of 8'hff. All-8'h00 memory gives 8'h00.
- Bit order: only pixel (col 0, row 3) set to INK, cell (5,2).
  - row 3 is 8'h80; every other row is 8'h00.
  - The first address is 10280.
  - A pixel value of 8'hfe decodes to 0.
- Rejects:
  - cell_x=80 → error pulse, no rd_en, busy stays 0.
  - cell_y=50 → same.
  - start pulsed at T+20 while busy → ignored; exactly 64 reads occur.
- Sweep RD_LATENCY at 1 and 4:
  - Row 0 row_valid at T+10 and T+13 respectively.
  - Row contents are identical for both settings.
- Reset:
  - Assert rst_n low at T+30 → all outputs 0 immediately.
  - After release, a new start at (1,1) yields a first address of 5128 and clean rows, with no residue from the aborted cell.
